// File: rtl/au_pkg.sv
// Shared encodings for the arithmetic sequencer: opcodes, FSM states, flag bit positions.
package au_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic [3:0] mk_flags(input logic c, input logic v, input logic z, input logic n);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction
endpackage

// File: rtl/au_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry, signed overflow, zero and negative.
module au_addsub
  import au_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic             o_v,
  output logic             o_z,
  output logic             o_n
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  // Subtraction is A + ~B + 1, so C=1 means no borrow.
  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_c    = w_full[WIDTH];
  assign o_v    = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign o_z    = (o_sum == '0);
  assign o_n    = o_sum[WIDTH-1];
endmodule

// File: rtl/au_seq_unit.sv
// Operand/result register unit: single-cycle ADD/SUB/ACC, WIDTH-cycle shift-add MUL,
// Start/Busy/Done handshake.
module au_seq_unit
  import au_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             Clear,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic [1:0]       Op,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rout,
  output logic [WIDTH-1:0] RoutHi,
  output logic [3:0]       Flags
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_a, r_b, r_r, r_hi;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_mcand, r_ph, r_pl;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a, w_b, w_sum;
  logic             w_sub, w_c, w_v, w_z, w_n;
  logic [WIDTH-1:0] w_ph_nxt, w_pl_nxt;
  logic             w_hi_nz;
  logic [3:0]       w_mul_flags;

  // One adder serves the single-cycle ops in IDLE and the partial-sum step in MUL.
  always_comb begin
    w_a   = r_a;
    w_b   = r_b;
    w_sub = 1'b0;
    if (r_state == ST_MUL) begin
      w_a = r_ph;
      w_b = r_pl[0] ? r_mcand : '0;
    end else if (Op == OP_SUB) begin
      w_sub = 1'b1;
    end else if (Op == OP_ACC) begin
      w_a = r_r;
      w_b = r_a;
    end
  end

  au_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_sub(w_sub),
    .o_sum(w_sum),
    .o_c  (w_c),
    .o_v  (w_v),
    .o_z  (w_z),
    .o_n  (w_n)
  );

  // Multiplier sits in the low half and shifts out as product bits shift in.
  assign w_ph_nxt    = {w_c, w_sum[WIDTH-1:1]};
  assign w_pl_nxt    = {w_sum[0], r_pl[WIDTH-1:1]};
  assign w_hi_nz     = |w_ph_nxt;
  assign w_mul_flags = mk_flags(w_hi_nz, w_hi_nz, ~w_hi_nz & ~(|w_pl_nxt), w_ph_nxt[WIDTH-1]);

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_mcand <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_cnt   <= '0;
    end else if (Clear) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_mcand <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LoadA) r_a <= X;
          if (LoadB) r_b <= Y;
          if (Start) begin
            r_busy <= 1'b1;
            if (Op == OP_MUL) begin
              if (MUL_EN) begin
                r_mcand <= r_a;
                r_pl    <= r_b;
                r_ph    <= '0;
                r_cnt   <= '0;
                r_state <= ST_MUL;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_r     <= w_sum;
              r_hi    <= '0;
              r_flags <= mk_flags(w_c, w_v, w_z, w_n);
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          r_ph  <= w_ph_nxt;
          r_pl  <= w_pl_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_r     <= w_pl_nxt;
            r_hi    <= w_ph_nxt;
            r_flags <= w_mul_flags;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Rout   = r_r;
  assign RoutHi = r_hi;
  assign Flags  = r_flags;
endmodule

// File: tb/tb_au_seq_unit.sv
// Directed bench for au_seq_unit (WIDTH=8): arithmetic, flags, MUL timing, Clear and async reset.
module tb_au_seq_unit;
  localparam int W = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, ACC = 2'b11;

  logic         CLK = 1'b0, CLR_n = 1'b0, Clear = 1'b0;
  logic         LoadA = 1'b0, LoadB = 1'b0, Start = 1'b0;
  logic [W-1:0] X = '0, Y = '0;
  logic [1:0]   Op = 2'b00;
  logic         Busy, Done;
  logic [W-1:0] Rout, RoutHi;
  logic [3:0]   Flags;

  int n_chk = 0;
  int n_fail = 0;
  int cycles;
  int pulses;

  always #5 CLK = ~CLK;

  au_seq_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .Clear(Clear), .X(X), .Y(Y),
    .LoadA(LoadA), .LoadB(LoadB), .Op(Op), .Start(Start),
    .Busy(Busy), .Done(Done), .Rout(Rout), .RoutHi(RoutHi), .Flags(Flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    X = a; Y = b; LoadA = 1'b1; LoadB = 1'b1;
    cyc();
    LoadA = 1'b0; LoadB = 1'b0;
  endtask

  task automatic op1(input string tag, input logic [1:0] op, input logic [W-1:0] r, input logic [3:0] f);
    Op = op; Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_busy"}, Busy, 1);
    chk({tag, "_r"}, Rout, r);
    chk({tag, "_hi"}, RoutHi, 0);
    chk({tag, "_flags"}, Flags, f);
    cyc();
    chk({tag, "_done_end"}, Done, 0);
    chk({tag, "_busy_end"}, Busy, 0);
  endtask

  task automatic wait_done(inout int c);
    while (!Done && c < 20) begin
      cyc();
      c++;
    end
  endtask

  initial begin
    #12;
    chk("rst_r", Rout, 0);
    chk("rst_hi", RoutHi, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(negedge CLK);
    CLR_n = 1'b1;
    cyc();

    load(8'h7F, 8'h01);
    op1("add_ovf", ADD, 8'h80, 4'b0101);
    load(8'h05, 8'h05);
    op1("sub_zero", SUB, 8'h00, 4'b1010);
    load(8'h00, 8'h01);
    op1("sub_borrow", SUB, 8'hFF, 4'b0001);

    load(8'hF0, 8'h00);
    op1("add_setup", ADD, 8'hF0, 4'b0001);
    X = 8'h20; LoadA = 1'b1;
    cyc();
    LoadA = 1'b0;
    op1("acc1", ACC, 8'h10, 4'b1000);
    op1("acc2", ACC, 8'h30, 4'b0000);

    // Load and Start at the same edge: the op sees the old A (0x20).
    X = 8'h55; LoadA = 1'b1;
    op1("add_preload", ADD, 8'h20, 4'b0000);
    LoadA = 1'b0;
    op1("add_newA", ADD, 8'h55, 4'b0000);

    load(8'hFF, 8'hFF);
    Op = MUL; Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("mulff_busy", Busy, 1);
    chk("mulff_nodone", Done, 0);
    X = 8'h03; LoadA = 1'b1;
    cyc();
    LoadA = 1'b0;
    cycles = 1;
    wait_done(cycles);
    chk("mulff_latency", cycles, 8);
    chk("mulff_lo", Rout, 8'h01);
    chk("mulff_hi", RoutHi, 8'hFE);
    chk("mulff_flags", Flags, 4'b1101);
    cyc();
    chk("mulff_idle", Busy, 0);
    op1("add_Akept", ADD, 8'hFE, 4'b1001);

    load(8'h0D, 8'h0B);
    Op = MUL; Start = 1'b1;
    cyc();
    Op = ADD;
    cyc();
    cyc();
    Start = 1'b0;
    cycles = 2;
    wait_done(cycles);
    chk("mul143_latency", cycles, 8);
    chk("mul143_lo", Rout, 8'h8F);
    chk("mul143_hi", RoutHi, 8'h00);
    chk("mul143_flags", Flags, 4'b0000);
    pulses = 0;
    repeat (10) begin
      cyc();
      if (Done) pulses++;
    end
    chk("mul_nosecond_done", pulses, 0);
    chk("mul_r_kept", Rout, 8'h8F);

    Op = MUL; Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc();
    cyc();
    Clear = 1'b1;
    cyc();
    Clear = 1'b0;
    chk("clr_busy", Busy, 0);
    chk("clr_done", Done, 0);
    chk("clr_r", Rout, 0);
    chk("clr_hi", RoutHi, 0);
    chk("clr_flags", Flags, 0);
    pulses = 0;
    repeat (10) begin
      cyc();
      if (Done) pulses++;
    end
    chk("clr_no_done", pulses, 0);
    op1("add_after_clr", ADD, 8'h00, 4'b0010);

    load(8'hFF, 8'hFF);
    op1("add_pre_rst", ADD, 8'hFE, 4'b1001);
    Op = MUL; Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("rstmul_busy_before", Busy, 1);
    #2 CLR_n = 1'b0;
    #1;
    chk("arst_r", Rout, 0);
    chk("arst_hi", RoutHi, 0);
    chk("arst_flags", Flags, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0);
    @(negedge CLK);
    CLR_n = 1'b1;
    cyc();
    chk("arst_idle", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
